ethernet_rx_irq_coalescer: RTL and testbench
============================================

// Module: ethernet_rx_irq_coalescer
// PURPOSE
//  RX interrupt moderation controller for the Ethernet controller.
//  Batches RX packet arrivals and raises one interrupt when a packet-count
//  threshold or a timeout is reached. Sits between the RX buffer
//  (arrival pulse, avail level) and the interrupt/MMIO path.
//  Software acknowledges the interrupt to start a new batch.
// PARAMETERS
//  count_width_p  8   width of batch packet counter and threshold
//  timer_width_p  16  width of timeout (cycles) and down-counter
// PORTS
//  clk_i            in   1              clock
//  reset_i          in   1              synchronous, active-high reset
//  pkt_arrive_i     in   1              pulse: one packet written into RX buffer
//  packet_avail_i   in   1              level: RX buffer non-empty
//  irq_ack_i        in   1              pulse: SW write-1-clear of RX irq
//  cfg_thresh_i     in   count_width_p  packets per interrupt (0 treated as 1)
//  cfg_thresh_v_i   in   1              write strobe for cfg_thresh_i
//  cfg_timeout_i    in   timer_width_p  cycles from first packet to irq (0 = off)
//  cfg_timeout_v_i  in   1              write strobe for cfg_timeout_i
//  cfg_enable_i     in   1              interrupt output enable
//  cfg_enable_v_i   in   1              write strobe for cfg_enable_i
//  irq_o            out  1              RX interrupt request (level)
//  batch_count_o    out  count_width_p  packets counted in current batch
//  state_o          out  2              FSM state, for status register
// BEHAVIOUR
//  Reset: state IDLE, count 0, timer 0, thresh_r 1, timeout_r 0, enable_r 0,
//   irq_o 0, batch_count_o 0, state_o 0.
//  Cfg regs: written on strobe; new value used from the next cycle. A running
//   timer is not reloaded by a timeout write.
//  count_next = saturating(count_r + pkt_arrive_i), sticks at 2^count_width_p-1.
//  thr_hit = count_next >= max(thresh_r,1).
//  IDLE(0): on arrive -> count 1, timer<=timeout_r, go FIRE if thr_hit, else COLLECT.
//  COLLECT(1): count<=count_next. Go FIRE if thr_hit, or if timeout_r!=0 and
//   timer_r==1. Otherwise timer decrements while it is non-zero.
//  FIRE(2): arrivals keep counting (saturating). On irq_ack_i:
//   count<=pkt_arrive_i; timer<=timeout_r.
//   Next state is COLLECT if (packet_avail_i|pkt_arrive_i), else IDLE.
//  irq_o = (state==FIRE) & enable_r. Registered state, so no comb path from inputs.
//  Latency: with thresh>1 and timeout T>0, irq_o rises exactly T edges after
//   the edge that samples the first arrival. With thresh<=1, irq_o rises on
//   the next edge.
//  Simultaneous arrive and timer expiry: go FIRE, and the arrival is counted.
//  Simultaneous arrive and ack in FIRE: go COLLECT with count 1.
//  irq_ack_i outside FIRE is ignored.
//  Disabling while in FIRE: state is held and irq_o drops. Re-enabling
//   reasserts irq_o the next cycle.
//  Timeout 0 with thresh never reached: stays in COLLECT indefinitely, by design.
//  Reset mid-batch: everything returns to reset values, and cfg is lost.
// STRUCTURE
//  Shared ethernet package: typedef enum logic [1:0] {e_coal_idle,
//   e_coal_collect, e_coal_fire} eth_rx_coal_state_e.
//  Config regs use bsg_dff_reset_en; thresh has reset value 1.
//  Sub-module: ethernet_coalesce_timer, a loadable down-counter with
//   load/en inputs and an expire_o output (timer==1 & en).
// TESTING
//  thresh=4, timeout=0, enable=1; 4 arrivals 3 cycles apart -> irq_o rises
//   the edge after the 4th arrival, batch_count_o=4.
//  thresh=8, timeout=20; 1 arrival -> irq_o rises exactly 20 edges later,
//   batch_count_o=1.
//  In FIRE, ack with packet_avail_i=1 -> state COLLECT, count 0, timer=20.
//   Ack with avail=0 -> IDLE.
//  Arrive on the same cycle as ack -> COLLECT with count 1. Arrive on the
//   timer==1 cycle -> FIRE with count incremented.
//  count_width_p=2, thresh=0 (acts as 1), enable=0; 5 arrivals in FIRE ->
//   count saturates at 3, irq_o=0. Set enable=1 -> irq_o=1 the next cycle.
//  Assert reset in COLLECT and in FIRE -> all outputs 0 the next cycle; a
//   later arrival with default cfg fires the next edge (thresh 1) but irq_o
//   stays 0 (enable 0).

Source files
------------

// File: rtl/ethernet_rx_irq_coalescer_pkg.sv
// Shared types for the Ethernet RX interrupt coalescer.
package ethernet_rx_irq_coalescer_pkg;

    localparam int unsigned coal_state_width_lp = 2;

    typedef enum logic [coal_state_width_lp-1:0] {
        e_coal_idle    = 2'd0,
        e_coal_collect = 2'd1,
        e_coal_fire    = 2'd2
    } eth_rx_coal_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with synchronous active-high reset to a parameterised value.
module bsg_dff_reset_en #(
    parameter int unsigned          width_p     = 1,
    parameter logic [width_p-1:0]   reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    // Capture data on enable; reset wins.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_o <= reset_val_p;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/ethernet_coalesce_timer.sv
// Loadable down-counter used as the coalescing timeout.
module ethernet_coalesce_timer #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic [width_p-1:0] load_val_i,
    input  logic               en_i,
    output logic               expire_o
);

    logic [width_p-1:0] timer_r;

    // Load has priority; otherwise count down while enabled and non-zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_r <= '0;
        end else if (load_i) begin
            timer_r <= load_val_i;
        end else if (en_i && (timer_r != '0)) begin
            timer_r <= timer_r - width_p'(1);
        end
    end

    assign expire_o = en_i & (timer_r == width_p'(1));

endmodule

// File: rtl/ethernet_rx_irq_coalescer.sv
// RX interrupt moderation: batches arrivals, fires on count threshold or timeout.
module ethernet_rx_irq_coalescer
    import ethernet_rx_irq_coalescer_pkg::*;
#(
    parameter int unsigned count_width_p = 8,
    parameter int unsigned timer_width_p = 16
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           pkt_arrive_i,
    input  logic                           packet_avail_i,
    input  logic                           irq_ack_i,
    input  logic [count_width_p-1:0]       cfg_thresh_i,
    input  logic                           cfg_thresh_v_i,
    input  logic [timer_width_p-1:0]       cfg_timeout_i,
    input  logic                           cfg_timeout_v_i,
    input  logic                           cfg_enable_i,
    input  logic                           cfg_enable_v_i,
    output logic                           irq_o,
    output logic [count_width_p-1:0]       batch_count_o,
    output logic [coal_state_width_lp-1:0] state_o
);

    localparam logic [count_width_p-1:0] count_max_lp = '1;

    eth_rx_coal_state_e        state_r, state_n;
    logic [count_width_p-1:0]  thresh_r, thresh_eff;
    logic [timer_width_p-1:0]  timeout_r;
    logic                      enable_r;
    logic [count_width_p-1:0]  count_r, count_n, count_next;
    logic                      thr_hit, timeout_hit, timer_expire, timer_load, timer_en;

    bsg_dff_reset_en #(.width_p(count_width_p), .reset_val_p(count_width_p'(1))) thresh_reg (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(cfg_thresh_v_i),
        .data_i(cfg_thresh_i), .data_o(thresh_r)
    );

    bsg_dff_reset_en #(.width_p(timer_width_p), .reset_val_p('0)) timeout_reg (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(cfg_timeout_v_i),
        .data_i(cfg_timeout_i), .data_o(timeout_r)
    );

    bsg_dff_reset_en #(.width_p(1), .reset_val_p(1'b0)) enable_reg (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(cfg_enable_v_i),
        .data_i(cfg_enable_i), .data_o(enable_r)
    );

    ethernet_coalesce_timer #(.width_p(timer_width_p)) timer (
        .clk_i(clk_i), .reset_i(reset_i), .load_i(timer_load),
        .load_val_i(timeout_r), .en_i(timer_en), .expire_o(timer_expire)
    );

    // Saturating arrival count and firing conditions; a threshold of 0 acts as 1.
    assign count_next  = (pkt_arrive_i && (count_r != count_max_lp)) ? count_r + count_width_p'(1) : count_r;
    assign thresh_eff  = (thresh_r == '0) ? count_width_p'(1) : thresh_r;
    assign thr_hit     = (count_next >= thresh_eff);
    assign timeout_hit = timer_expire & (timeout_r != '0);
    assign timer_en    = (state_r == e_coal_collect);

    // State and batch count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= e_coal_idle;
            count_r <= '0;
        end else begin
            state_r <= state_n;
            count_r <= count_n;
        end
    end

    // Next-state selection.
    always_comb begin
        state_n = state_r;
        unique case (state_r)
            e_coal_idle: begin
                if (pkt_arrive_i) state_n = thr_hit ? e_coal_fire : e_coal_collect;
            end
            e_coal_collect: begin
                if (thr_hit || timeout_hit) state_n = e_coal_fire;
            end
            e_coal_fire: begin
                if (irq_ack_i) state_n = (packet_avail_i | pkt_arrive_i) ? e_coal_collect : e_coal_idle;
            end
            default: state_n = e_coal_idle;
        endcase
    end

    // Count/timer control and status outputs.
    always_comb begin
        count_n       = count_r;
        timer_load    = 1'b0;
        irq_o         = (state_r == e_coal_fire) & enable_r;
        batch_count_o = count_r;
        state_o       = state_r;
        unique case (state_r)
            e_coal_idle: begin
                if (pkt_arrive_i) begin
                    count_n    = count_width_p'(1);
                    timer_load = 1'b1;
                end
            end
            e_coal_collect: count_n = count_next;
            e_coal_fire: begin
                if (irq_ack_i) begin
                    count_n    = count_width_p'(pkt_arrive_i);
                    timer_load = 1'b1;
                end else begin
                    count_n = count_next;
                end
            end
            default: count_n = '0;
        endcase
    end

endmodule

// File: tb/tb_ethernet_rx_irq_coalescer.sv
// Scoreboard bench for the RX interrupt coalescer (8-bit and 2-bit count instances).
module tb_ethernet_rx_irq_coalescer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance a: default widths.
    logic        a_reset = 1'b1, a_arr = 1'b0, a_avail = 1'b0, a_ack = 1'b0;
    logic [7:0]  a_thresh = '0;
    logic        a_thresh_v = 1'b0;
    logic [15:0] a_timeout = '0;
    logic        a_timeout_v = 1'b0, a_en = 1'b0, a_en_v = 1'b0;
    logic        a_irq;
    logic [7:0]  a_count;
    logic [1:0]  a_state;

    // Instance b: 2-bit count for saturation.
    logic        b_reset = 1'b1, b_arr = 1'b0, b_avail = 1'b0, b_ack = 1'b0;
    logic [1:0]  b_thresh = '0;
    logic        b_thresh_v = 1'b0;
    logic [15:0] b_timeout = '0;
    logic        b_timeout_v = 1'b0, b_en = 1'b0, b_en_v = 1'b0;
    logic        b_irq;
    logic [1:0]  b_count;
    logic [1:0]  b_state;

    ethernet_rx_irq_coalescer #(.count_width_p(8), .timer_width_p(16)) dut_a (
        .clk_i(clk), .reset_i(a_reset), .pkt_arrive_i(a_arr), .packet_avail_i(a_avail),
        .irq_ack_i(a_ack), .cfg_thresh_i(a_thresh), .cfg_thresh_v_i(a_thresh_v),
        .cfg_timeout_i(a_timeout), .cfg_timeout_v_i(a_timeout_v),
        .cfg_enable_i(a_en), .cfg_enable_v_i(a_en_v),
        .irq_o(a_irq), .batch_count_o(a_count), .state_o(a_state)
    );

    ethernet_rx_irq_coalescer #(.count_width_p(2), .timer_width_p(16)) dut_b (
        .clk_i(clk), .reset_i(b_reset), .pkt_arrive_i(b_arr), .packet_avail_i(b_avail),
        .irq_ack_i(b_ack), .cfg_thresh_i(b_thresh), .cfg_thresh_v_i(b_thresh_v),
        .cfg_timeout_i(b_timeout), .cfg_timeout_v_i(b_timeout_v),
        .cfg_enable_i(b_en), .cfg_enable_v_i(b_en_v),
        .irq_o(b_irq), .batch_count_o(b_count), .state_o(b_state)
    );

    typedef struct {
        int    at;
        bit    sel;
        bit    irq;
        int    cnt;
        int    st;
        string name;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // Queue an expected observation d edges from now on instance sel.
    task automatic expect_at(input int d, input bit sel, input bit irq, input int cnt,
                             input int st, input string name);
        exp_t e;
        e.at = cyc + d; e.sel = sel; e.irq = irq; e.cnt = cnt; e.st = st; e.name = name;
        q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation due on this cycle, flag any that were missed.
    logic act_irq;
    int   act_cnt, act_st;
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at < cyc) begin
                checks++;
                failures++;
                $display("FAIL %s: expectation for cycle %0d never observed", q[i].name, q[i].at);
                q.delete(i);
            end else if (q[i].at == cyc) begin
                act_irq = q[i].sel ? b_irq : a_irq;
                act_cnt = q[i].sel ? int'(b_count) : int'(a_count);
                act_st  = q[i].sel ? int'(b_state) : int'(a_state);
                checks++;
                if (act_irq !== q[i].irq || act_cnt != q[i].cnt || act_st != q[i].st) begin
                    failures++;
                    $display("FAIL %s: got irq=%0b count=%0d state=%0d, expected irq=%0b count=%0d state=%0d",
                             q[i].name, act_irq, act_cnt, act_st, q[i].irq, q[i].cnt, q[i].st);
                end
                q.delete(i);
            end
        end
    end

    initial begin
        // Reset both instances.
        tick(2);
        expect_at(0, 0, 0, 0, 0, "a_reset");
        expect_at(0, 1, 0, 0, 0, "b_reset");
        tick(1);
        a_reset = 0; b_reset = 0;

        // Threshold 4, no timeout, enabled.
        a_thresh = 8'd4; a_thresh_v = 1; a_timeout = 16'd0; a_timeout_v = 1; a_en = 1; a_en_v = 1;
        tick(1);
        a_thresh_v = 0; a_timeout_v = 0; a_en_v = 0;
        for (int k = 1; k <= 4; k++) begin
            a_arr = 1;
            if (k < 4) expect_at(1, 0, 0, k, 1, "thr_collect");
            else       expect_at(1, 0, 1, 4, 2, "thr_fire");
            tick(1);
            a_arr = 0;
            tick(2);
        end

        // Ack with nothing pending returns to idle.
        a_ack = 1;
        expect_at(1, 0, 0, 0, 0, "ack_idle");
        tick(1);
        a_ack = 0;

        // Threshold 8, timeout 20: single arrival fires exactly 20 edges later.
        a_thresh = 8'd8; a_thresh_v = 1; a_timeout = 16'd20; a_timeout_v = 1;
        tick(1);
        a_thresh_v = 0; a_timeout_v = 0;
        a_arr = 1;
        expect_at(1, 0, 0, 1, 1, "to_first");
        expect_at(20, 0, 0, 1, 1, "to_edge19");
        expect_at(21, 0, 1, 1, 2, "to_fire");
        tick(1);
        a_arr = 0;
        tick(20);

        // Ack with avail: collect with count 0, timer reloaded to 20.
        a_avail = 1; a_ack = 1;
        expect_at(1, 0, 0, 0, 1, "ack_avail");
        tick(1);
        a_avail = 0; a_ack = 0;
        expect_at(19, 0, 0, 0, 1, "reload_edge19");
        expect_at(20, 0, 1, 0, 2, "reload_fire");
        // Timeout write does not reload the running timer; ack outside fire ignored.
        tick(3);
        a_timeout = 16'd50; a_timeout_v = 1;
        tick(1);
        a_timeout_v = 0;
        tick(4);
        a_ack = 1;
        tick(1);
        a_ack = 0;
        tick(3);
        a_timeout = 16'd20; a_timeout_v = 1;
        tick(1);
        a_timeout_v = 0;
        tick(7);

        // Arrival coincident with ack: collect with count 1.
        a_arr = 1; a_ack = 1;
        expect_at(1, 0, 0, 1, 1, "ack_arrive");
        tick(1);
        a_arr = 0; a_ack = 0;
        // Arrival on the timer==1 cycle: fire and count it.
        tick(19);
        a_arr = 1;
        expect_at(0, 0, 0, 1, 1, "pre_expiry");
        expect_at(1, 0, 1, 2, 2, "arrive_on_expiry");
        tick(1);
        a_arr = 0;

        // Disable drops irq while holding fire; re-enable restores it.
        a_en = 0; a_en_v = 1;
        expect_at(1, 0, 0, 2, 2, "disabled");
        tick(1);
        a_en = 1;
        expect_at(1, 0, 1, 2, 2, "reenabled");
        tick(1);
        a_en_v = 0;

        // Reset in fire, then default cfg fires immediately with irq masked.
        a_reset = 1;
        expect_at(1, 0, 0, 0, 0, "rst_fire");
        tick(1);
        a_reset = 0;
        a_arr = 1;
        expect_at(1, 0, 0, 1, 2, "post_rst_fire");
        tick(1);
        a_arr = 0;
        a_ack = 1;
        expect_at(1, 0, 0, 0, 0, "ack_idle2");
        tick(1);
        a_ack = 0;

        // Reset in collect.
        a_thresh = 8'd8; a_thresh_v = 1;
        tick(1);
        a_thresh_v = 0;
        a_arr = 1;
        expect_at(1, 0, 0, 1, 1, "collect_pre_rst");
        tick(1);
        a_arr = 0;
        a_reset = 1;
        expect_at(1, 0, 0, 0, 0, "rst_collect");
        tick(1);
        a_reset = 0;
        a_arr = 1;
        expect_at(1, 0, 0, 1, 2, "post_rst_collect");
        tick(1);
        a_arr = 0;

        // Instance b: threshold 0 acts as 1, count saturates at 3, irq masked.
        b_thresh = 2'd0; b_thresh_v = 1;
        tick(1);
        b_thresh_v = 0;
        b_arr = 1;
        expect_at(1, 1, 0, 1, 2, "sat_1");
        expect_at(2, 1, 0, 2, 2, "sat_2");
        expect_at(3, 1, 0, 3, 2, "sat_3");
        expect_at(4, 1, 0, 3, 2, "sat_4");
        expect_at(5, 1, 0, 3, 2, "sat_5");
        tick(5);
        b_arr = 0;
        b_en = 1; b_en_v = 1;
        expect_at(1, 1, 1, 3, 2, "sat_enable");
        tick(1);
        b_en_v = 0;

        tick(2);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
